// File: rtl/scan_mux_if.sv
// ---------------------------------------------------------------------------
// scan_mux_if
// Bundles the channel data, select/control inputs and registered outputs of
// scan_mux into one interface.
//   din      : N*W   channel data, channel i at din[i*W +: W]
//   sel      : SELW  manual channel select / scan start channel
//   mode     : 1     0 = manual, 1 = scan
//   hold     : 1     freeze all mux state while high
//   op       : W     registered selected data
//   ch       : SELW  channel index that op came from
//   op_valid : 1     op was updated by the previous edge
//   wrap     : 1     one-cycle pulse when the scan wraps N-1 -> 0
// master drives the inputs and observes the outputs; slave is the mux.
// ---------------------------------------------------------------------------
interface scan_mux_if #(
    parameter int W    = 8,
    parameter int N    = 4,
    parameter int SELW = 2
);
    logic [N*W-1:0]  din;
    logic [SELW-1:0] sel;
    logic            mode;
    logic            hold;
    logic [W-1:0]    op;
    logic [SELW-1:0] ch;
    logic            op_valid;
    logic            wrap;

    modport master (
        output din, sel, mode, hold,
        input  op, ch, op_valid, wrap
    );

    modport slave (
        input  din, sel, mode, hold,
        output op, ch, op_valid, wrap
    );
endinterface

// File: rtl/scan_mux.sv
// ---------------------------------------------------------------------------
// scan_mux
// Registered N-channel, W-bit multiplexer. In manual mode the output follows
// sel one cycle later; in scan mode it steps through every channel, staying
// DWELL non-held cycles on each, starting from the channel selected at entry.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : scan_mux_if.slave (din/sel/mode/hold in, op/ch/op_valid/wrap out)
// Parameters: W data width, N channel count (power of two), SELW = log2(N),
// DWELL cycles per channel in scan mode (>= 1).
// ---------------------------------------------------------------------------
module scan_mux #(
    parameter int W     = 8,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int DWELL = 4
) (
    input  logic        clk,
    input  logic        rst,
    scan_mux_if.slave   bus
);
    localparam int              CNTW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST  = SELW'(N - 1);

    typedef enum logic {
        ST_MANUAL,
        ST_SCAN
    } state_t;

    state_t          r_state;
    logic [CNTW-1:0] r_cnt;
    logic [SELW-1:0] r_ch;
    logic [W-1:0]    r_op;
    logic            r_op_valid;
    logic            r_wrap;

    logic [W-1:0]    w_chan [N];
    logic [SELW-1:0] w_src_ch;

    for (genvar i = 0; i < N; i++) begin : g_chan
        assign w_chan[i] = bus.din[i*W +: W];
    end

    // Channel to load on the next non-held edge. Manual mode and scan entry
    // both take sel; a running scan keeps its channel until the dwell ends,
    // then advances with natural SELW-bit wraparound.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_src_ch = bus.sel;
        if (bus.mode && r_state == ST_SCAN) begin
            if (r_cnt == CNT_LAST) begin
                w_src_ch = r_ch + SELW'(1);
            end else begin
                w_src_ch = r_ch;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_MANUAL;
            r_cnt      <= '0;
            r_ch       <= '0;
            r_op       <= '0;
            r_op_valid <= 1'b0;
            r_wrap     <= 1'b0;
        end else if (bus.hold) begin
            // Held edges do not count toward the dwell; only the
            // per-cycle flags drop.
            r_op_valid <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_op_valid <= 1'b1;
            // Live data of the chosen channel is resampled every cycle.
            r_op       <= w_chan[w_src_ch];
            r_ch       <= w_src_ch;
            r_cnt      <= '0;
            r_wrap     <= 1'b0;
            if (!bus.mode) begin
                r_state <= ST_MANUAL;
            end else if (r_state == ST_MANUAL) begin
                r_state <= ST_SCAN;
            end else if (r_cnt != CNT_LAST) begin
                r_cnt <= r_cnt + CNTW'(1);
            end else begin
                r_wrap <= (r_ch == CH_LAST);
            end
        end
    end

    assign bus.op       = r_op;
    assign bus.ch       = r_ch;
    assign bus.op_valid = r_op_valid;
    assign bus.wrap     = r_wrap;

endmodule

// File: tb/tb_scan_mux.sv
// ---------------------------------------------------------------------------
// tb_scan_mux
// Directed bench for scan_mux with W=8, N=4, DWELL=3 and channel data
// 0x11, 0x22, 0x33, 0x44. Outputs are sampled 1 ns after each rising edge.
// ---------------------------------------------------------------------------
module tb_scan_mux;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int SELW  = 2;
    localparam int DWELL = 3;

    logic clk;
    logic rst;
    int   n_total;
    int   n_bad;

    scan_mux_if #(.W(W), .N(N), .SELW(SELW)) bus ();

    scan_mux #(.W(W), .N(N), .SELW(SELW), .DWELL(DWELL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] op, input logic [1:0] ch,
                              input logic vld, input logic wrp);
        check({tag, ".op"},       bus.op,       op);
        check({tag, ".ch"},       bus.ch,       ch);
        check({tag, ".op_valid"}, bus.op_valid, vld);
        check({tag, ".wrap"},     bus.wrap,     wrp);
    endtask

    logic [7:0] chan_val [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    // Scan from channel 2: expected channel per edge, wrap only entering ch 0.
    logic [1:0] scan_ch   [10] = '{2, 2, 2, 3, 3, 3, 0, 0, 0, 1};
    logic       scan_wrap [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    // Manual steps: sel then expected op.
    logic [1:0] man_sel   [3]  = '{3, 1, 2};
    // From ch 0 / cnt 1 to ch 3 / cnt 2.
    logic [1:0] run_ch    [10] = '{0, 1, 1, 1, 2, 2, 2, 3, 3, 3};

    initial begin
        n_total  = 0;
        n_bad    = 0;
        rst      = 1'b1;
        bus.din  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.sel  = 2'd0;
        bus.mode = 1'b0;
        bus.hold = 1'b0;

        // Reset values, then first edge after release.
        #12;
        expect_out("reset", 8'h00, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        expect_out("first_edge", 8'h11, 2'd0, 1'b1, 1'b0);

        // Manual select.
        for (int i = 0; i < 3; i++) begin
            bus.sel = man_sel[i];
            tick();
            expect_out($sformatf("manual%0d", i), chan_val[man_sel[i]], man_sel[i], 1'b1, 1'b0);
        end

        // Scan entry from channel 2; sel wiggles during the scan.
        bus.mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_out($sformatf("scan%0d", i), chan_val[scan_ch[i]], scan_ch[i], 1'b1, scan_wrap[i]);
            bus.sel = 2'(i + 1);
        end

        // Hold on the first cycle of ch 1: frozen, flags low.
        bus.hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_out($sformatf("hold%0d", i), 8'h22, 2'd1, 1'b0, 1'b0);
        end
        bus.hold = 1'b0;
        tick();
        expect_out("unhold0", 8'h22, 2'd1, 1'b1, 1'b0);
        tick();
        expect_out("unhold1", 8'h22, 2'd1, 1'b1, 1'b0);
        tick();
        expect_out("unhold2", 8'h33, 2'd2, 1'b1, 1'b0);

        // Walk to ch 3 and leave scan with sel=1.
        tick();
        tick();
        tick();
        check("pre_exit.ch", bus.ch, 2'd3);
        bus.mode = 1'b0;
        bus.sel  = 2'd1;
        tick();
        expect_out("exit", 8'h22, 2'd1, 1'b1, 1'b0);

        // Live data while dwelling on ch 0.
        bus.mode = 1'b1;
        bus.sel  = 2'd0;
        tick();
        expect_out("live_entry", 8'h11, 2'd0, 1'b1, 1'b0);
        bus.din[7:0] = 8'h5A;
        tick();
        expect_out("live_update", 8'h5A, 2'd0, 1'b1, 1'b0);
        bus.din[7:0] = 8'h11;

        // Advance to ch 3 with cnt 2.
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("run%0d.ch", i), bus.ch, run_ch[i]);
        end

        // Async reset pulse between edges.
        #2;
        rst = 1'b1;
        #1;
        expect_out("async_rst", 8'h00, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        bus.mode = 1'b1;
        bus.sel  = 2'd0;
        tick();
        expect_out("restart0", 8'h11, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("restart1", 8'h11, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("restart2", 8'h11, 2'd0, 1'b1, 1'b0);
        tick();
        expect_out("restart3", 8'h22, 2'd1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
